// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared constants and APB decode helpers for the APB timer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: register byte offsets, CTRL/STATUS bit indices, phase decode helpers.
package apb_timer_pkg;

  // Register byte offsets; only bits [7:2] take part in decode.
  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PRESC  = 8'h04;
  localparam logic [7:0] TMR_LOAD   = 8'h08;
  localparam logic [7:0] TMR_COUNT  = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;

  // CTRL bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;

  // STATUS bit indices
  localparam int STAT_IF      = 0;
  localparam int STAT_RUNNING = 1;

  // Write commits in the access phase.
  function automatic logic apb_write(input logic psel, input logic penable,
                                     input logic pwrite);
    return psel & penable & pwrite;
  endfunction

  // Read data is captured in the setup phase so it is already stable when
  // the bridge samples PRDATA combinationally during the access phase.
  function automatic logic apb_read_setup(input logic psel, input logic penable,
                                          input logic pwrite);
    return psel & ~penable & ~pwrite;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (presc+1), emitting a one-cycle tick.
// Latency: tick is combinational from the counter flops; first tick presc+1 cycles after en rises.
// Backpressure: none; clr restarts the divide and suppresses the tick of that cycle.
// Ports: clk, rst (sync, active-high), en (run), clr (restart), presc (divide-1), tick (out).
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               match;

  // Equality compare, so a smaller presc written while presc_cnt is above it
  // lets the counter run through its natural wrap before matching again.
  assign match = (presc_cnt == presc);
  assign tick  = en & ~clr & match;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (!en || clr || match) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/apb_timer.sv
// apb_timer: zero-wait-state APB timer with prescaler, period compare and maskable IRQ.
// Latency: writes commit at the access edge; PRDATA is captured at the setup edge; IRQ is flop-driven.
// Backpressure: none; there is no PREADY, every transfer completes in setup + access.
// Ports: HCLK, HRST (sync, active-high), PSEL/PENABLE/PWRITE/PADDR/PWDATA (APB in),
//        PRDATA (registered read data), IRQ (IF & IE level interrupt).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W   = 32,  // counter/period width, at most 32
  parameter int PRESC_W = 16   // prescaler width, at most 32
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  logic               ctrl_en;
  logic               ctrl_oneshot;
  logic               ctrl_ie;
  logic               irq_flag;
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   load;
  logic [CNT_W-1:0]   count;

  logic [7:0]         reg_off;
  logic               wr_xfer;
  logic               rd_setup;
  logic               wr_ctrl;
  logic               wr_presc;
  logic               wr_load;
  logic               wr_count;
  logic               wr_status;
  logic               tick;
  logic               expire;
  logic [31:0]        rd_data;

  // Address bits outside [7:2] alias onto the same registers.
  logic               unused_addr;
  assign unused_addr = &{1'b0, PADDR[31:8], PADDR[1:0]};

  assign reg_off  = {PADDR[7:2], 2'b00};
  assign wr_xfer  = apb_write(PSEL, PENABLE, PWRITE);
  assign rd_setup = apb_read_setup(PSEL, PENABLE, PWRITE);

  // Write strobe decode
  always_comb begin
    wr_ctrl   = 1'b0;
    wr_presc  = 1'b0;
    wr_load   = 1'b0;
    wr_count  = 1'b0;
    wr_status = 1'b0;
    if (wr_xfer) begin
      case (reg_off)
        TMR_CTRL:   wr_ctrl   = 1'b1;
        TMR_PRESC:  wr_presc  = 1'b1;
        TMR_LOAD:   wr_load   = 1'b1;
        TMR_COUNT:  wr_count  = 1'b1;
        TMR_STATUS: wr_status = 1'b1;
        default:    ;
      endcase
    end
  end

  // Read mux; unused upper bits and unmapped offsets return zero.
  always_comb begin
    rd_data = '0;
    case (reg_off)
      TMR_CTRL: begin
        rd_data[CTRL_EN]      = ctrl_en;
        rd_data[CTRL_ONESHOT] = ctrl_oneshot;
        rd_data[CTRL_IE]      = ctrl_ie;
      end
      TMR_PRESC: rd_data[PRESC_W-1:0] = presc;
      TMR_LOAD:  rd_data[CNT_W-1:0]   = load;
      TMR_COUNT: rd_data[CNT_W-1:0]   = count;
      TMR_STATUS: begin
        rd_data[STAT_IF]      = irq_flag;
        rd_data[STAT_RUNNING] = ctrl_en;
      end
      default: ;
    endcase
  end

  // A COUNT write restarts the prescaler and swallows that cycle's tick.
  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (HCLK),
    .rst   (HRST),
    .en    (ctrl_en),
    .clr   (wr_count),
    .presc (presc),
    .tick  (tick)
  );

  // Period end: only an equality hit counts, so a counter left above LOAD
  // rolls over at 2^CNT_W silently and then compares normally.
  assign expire = tick & (count == load);

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_ie      <= 1'b0;
      presc        <= '0;
      load         <= '0;
      count        <= '0;
      irq_flag     <= 1'b0;
      PRDATA       <= '0;
    end else begin
      // Software CTRL write takes priority over the one-shot auto-clear.
      if (wr_ctrl) begin
        ctrl_en      <= PWDATA[CTRL_EN];
        ctrl_oneshot <= PWDATA[CTRL_ONESHOT];
        ctrl_ie      <= PWDATA[CTRL_IE];
      end else if (expire && ctrl_oneshot) begin
        ctrl_en <= 1'b0;
      end

      if (wr_presc) presc <= PWDATA[PRESC_W-1:0];
      if (wr_load)  load  <= PWDATA[CNT_W-1:0];

      if (wr_count) begin
        count <= PWDATA[CNT_W-1:0];
      end else if (expire) begin
        count <= '0;
      end else if (tick) begin
        count <= count + CNT_W'(1);
      end

      // Hardware set beats a simultaneous write-1-to-clear.
      if (expire) begin
        irq_flag <= 1'b1;
      end else if (wr_status && PWDATA[STAT_IF]) begin
        irq_flag <= 1'b0;
      end

      // Captures pre-edge register values, so a STATUS read racing an IF
      // set returns the old flag.
      if (rd_setup) PRDATA <= rd_data;
    end
  end

  assign IRQ = irq_flag & ctrl_ie;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed + randomized APB traffic against a cycle reference model of the timer.
// Latency: model advances once per HCLK edge using the inputs present before that edge.
// Backpressure: n/a; every transfer is setup + access with no wait states.
module tb_apb_timer;

  logic        HCLK;
  logic        HRST;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (register-level view of the timer)
  bit        m_en, m_one, m_ie, m_if;
  bit [15:0] m_presc, m_pc;
  bit [31:0] m_load, m_count, m_prdata;

  apb_timer dut (
    .HCLK    (HCLK),
    .HRST    (HRST),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit [31:0] model_reg(input bit [7:0] off);
    case (off)
      8'h00:   return {29'd0, m_ie, m_one, m_en};
      8'h04:   return {16'd0, m_presc};
      8'h08:   return m_load;
      8'h0C:   return m_count;
      8'h10:   return {30'd0, m_en, m_if};
      default: return 32'd0;
    endcase
  endfunction

  // One HCLK edge of the timer as described by its register rules.
  task automatic model_step();
    bit        wr, rd, tick, hit;
    bit [7:0]  off;
    bit [31:0] d;
    wr  = PSEL && PENABLE && PWRITE;
    rd  = PSEL && !PENABLE && !PWRITE;
    off = {PADDR[7:2], 2'b00};
    d   = PWDATA;
    if (HRST) begin
      m_en = 0; m_one = 0; m_ie = 0; m_if = 0;
      m_presc = 0; m_pc = 0; m_load = 0; m_count = 0; m_prdata = 0;
      return;
    end
    if (rd) m_prdata = model_reg(off);
    tick = m_en && (m_pc == m_presc);
    hit  = 0;
    if (!m_en || tick) m_pc = 0;
    else m_pc = m_pc + 16'd1;
    if (wr && off == 8'h0C) begin
      m_count = d;
      m_pc    = 0;
    end else if (tick) begin
      if (m_count == m_load) begin
        m_count = 0;
        hit     = 1;
      end else begin
        m_count = m_count + 32'd1;
      end
    end
    if (hit && m_one) m_en = 0;
    if (hit) m_if = 1;
    else if (wr && off == 8'h10 && d[0]) m_if = 0;
    if (wr && off == 8'h00) {m_ie, m_one, m_en} = d[2:0];
    if (wr && off == 8'h04) m_presc = d[15:0];
    if (wr && off == 8'h08) m_load = d;
  endtask

  // Advance one edge; outputs are compared 1 time unit after it.
  task automatic cycle();
    model_step();
    @(posedge HCLK);
    #1;
    check("irq", 32'(IRQ), 32'(m_if & m_ie));
    check("prdata", PRDATA, m_prdata);
  endtask

  task automatic idle(input int n);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    repeat (n) cycle();
  endtask

  task automatic setup_wr(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    cycle();
  endtask

  task automatic access();
    PENABLE = 1;
    cycle();
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    setup_wr(a, d);
    access();
  endtask

  // Returns PRDATA as seen during the access phase.
  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    cycle();
    d = PRDATA;
    access();
  endtask

  initial begin
    logic [31:0] r;
    HRST = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    cycle();
    cycle();
    HRST = 0;
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);

    // Register access
    apb_wr(32'h08, 32'hDEADBEEF);
    apb_rd(32'h08, r);               check("load_rd", r, 32'hDEADBEEF);
    apb_rd(32'h20, r);               check("unmapped_rd", r, 32'd0);
    apb_wr(32'h04, 32'hFFFF1234);
    apb_rd(32'h04, r);               check("presc_trunc", r, 32'h0000_1234);
    apb_wr(32'h08, 32'h55);
    apb_rd(32'h08, r);               check("b2b_load", r, 32'h55);
    apb_wr(32'h00, 32'hFFFFFFF8);
    apb_rd(32'h00, r);               check("ctrl_upper", r, 32'd0);

    // Periodic: PRESC=0, LOAD=3, CTRL=EN|IE committed at E0
    apb_wr(32'h04, 32'd0);
    apb_wr(32'h08, 32'd3);
    apb_wr(32'h0C, 32'd0);
    apb_wr(32'h00, 32'h5);
    idle(3);                         check("per_irq_e3", 32'(IRQ), 32'd0);
    setup_wr(32'h10, 32'h1);         check("per_irq_e4", 32'(IRQ), 32'd1);
    access();                        check("per_w1c_e5", 32'(IRQ), 32'd0);
    idle(2);                         check("per_irq_e7", 32'(IRQ), 32'd0);
    idle(1);                         check("per_irq_e8", 32'(IRQ), 32'd1);
    apb_rd(32'h0C, r);               check("per_count_e8", r, 32'd0);
    // W1C commits on E12, the same edge IF sets again
    apb_wr(32'h10, 32'h1);
    apb_rd(32'h10, r);               check("w1c_collide", r, 32'h3);
    // COUNT write on a tick edge, read back with no idle cycle
    apb_wr(32'h0C, 32'd7);
    apb_rd(32'h0C, r);               check("count_wr_tick", r, 32'd7);

    // Reset mid-count, with a concurrent write that must be ignored
    apb_wr(32'h0C, 32'd5);           check("pre_rst_irq", 32'(IRQ), 32'd1);
    HRST = 1; PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h08; PWDATA = 32'hAA;
    cycle();
    HRST = 0;
    idle(1);                         check("rst_mid_irq", 32'(IRQ), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apb_rd(32'(i * 4), r);
      check("rst_mid_reg", r, 32'd0);
    end

    // Prescaled one-shot: PRESC=2, LOAD=1, CTRL=EN|ONESHOT at E0
    apb_wr(32'h04, 32'd2);
    apb_wr(32'h08, 32'd1);
    apb_wr(32'h00, 32'h3);
    idle(5);
    apb_rd(32'h10, r);               check("os_status_old", r, 32'h2);
    apb_rd(32'h10, r);               check("os_status_done", r, 32'h1);
    apb_rd(32'h00, r);               check("os_ctrl", r, 32'h2);
    idle(10);
    apb_rd(32'h0C, r);               check("os_count_hold", r, 32'd0);

    // Randomized traffic; every cycle compares PRDATA and IRQ to the model
    for (int i = 0; i < 700; i++) begin
      int          k;
      logic [31:0] a, d;
      k = $urandom_range(0, 99);
      if (k < 3) begin
        HRST = 1;
        idle(1);
        HRST = 0;
      end else begin
        idle($urandom_range(0, 2));
        a = $urandom();
        case ($urandom_range(0, 6))
          0: begin a[7:0] = 8'h00; d = $urandom(); d[0] = ($urandom_range(0, 3) != 0); end
          1: begin a[7:0] = 8'h04; d = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 3); end
          2: begin a[7:0] = 8'h08; d = $urandom_range(0, 8); end
          3: begin a[7:0] = 8'h0C; d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom_range(0, 10); end
          4: begin a[7:0] = 8'h10; d = $urandom(); end
          5: begin a[7:0] = 8'h20; d = $urandom(); end
          default: begin a[7:0] = 8'(($urandom_range(5, 63)) * 4); d = $urandom(); end
        endcase
        if ($urandom_range(0, 9) < 4) apb_wr(a, d);
        else apb_rd(a, r);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
